// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter that merges ALU and memory writebacks, each queued in its own FIFO, onto one registered register-file write port.
// Optional WB_BYPASS_EN: an entry arriving at an empty FIFO whose requester wins arbitration goes straight to the write port.

module rf_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: storage has no reset; an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
endmodule

module rf_write_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_wb_valid,
  input  logic [ADDR_W-1:0] alu_wb_addr,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              mem_wb_valid,
  input  logic [ADDR_W-1:0] mem_wb_addr,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic              mem_wb_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              wb_pending
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  grant_e     last_grant;
  wb_entry_t  alu_in, mem_in, alu_head, mem_head, win_entry;
  logic [CNT_W-1:0] alu_count, mem_count;
  logic alu_empty, mem_empty, alu_req, mem_req;
  logic grant_alu, grant_mem, alu_bypass, mem_bypass;
  logic alu_push, mem_push, alu_pop, mem_pop;

  assign alu_in = '{addr: alu_wb_addr, data: alu_wb_data};
  assign mem_in = '{addr: mem_wb_addr, data: mem_wb_data};

  // Ready comes from the registered count only, so a full FIFO refuses even while popping.
  assign alu_wb_ready = alu_count < CNT_W'(FIFO_DEPTH);
  assign mem_wb_ready = mem_count < CNT_W'(FIFO_DEPTH);
  assign alu_empty    = alu_count == '0;
  assign mem_empty    = mem_count == '0;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    alu_req    = !alu_empty;
    mem_req    = !mem_empty;
    alu_bypass = 1'b0;
    mem_bypass = 1'b0;
`ifdef WB_BYPASS_EN
    alu_req    = alu_req || alu_wb_valid;
    mem_req    = mem_req || mem_wb_valid;
`else
    alu_req    = alu_req;
    mem_req    = mem_req;
`endif
    grant_alu  = alu_req && (!mem_req || last_grant == GRANT_MEM);
    grant_mem  = mem_req && !grant_alu;
`ifdef WB_BYPASS_EN
    alu_bypass = grant_alu && alu_empty;
    mem_bypass = grant_mem && mem_empty;
`else
    alu_bypass = 1'b0;
    mem_bypass = 1'b0;
`endif
    alu_push   = alu_wb_valid && alu_wb_ready && !alu_bypass;
    mem_push   = mem_wb_valid && mem_wb_ready && !mem_bypass;
    alu_pop    = grant_alu && !alu_empty;
    mem_pop    = grant_mem && !mem_empty;
    win_entry  = '0;
    if (grant_alu)      win_entry = alu_bypass ? alu_in : alu_head;
    else if (grant_mem) win_entry = mem_bypass ? mem_in : mem_head;
  end

  rf_wb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(wb_entry_t))) u_alu_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (alu_push),
    .pop   (alu_pop),
    .din   (alu_in),
    .head  (alu_head),
    .count (alu_count)
  );

  rf_wb_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(wb_entry_t))) u_mem_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (mem_push),
    .pop   (mem_pop),
    .din   (mem_in),
    .head  (mem_head),
    .count (mem_count)
  );

  // Address and data hold their last value when no grant is made.
  always_ff @(posedge clk) begin
    if (!reset) begin
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      last_grant <= GRANT_MEM;
    end else begin
      write_en <= grant_alu || grant_mem;
      if (grant_alu || grant_mem) begin
        write_addr <= win_entry.addr;
        write_data <= win_entry.data;
      end
      if (grant_alu)      last_grant <= GRANT_ALU;
      else if (grant_mem) last_grant <= GRANT_MEM;
    end
  end

  assign wb_pending = !alu_empty || !mem_empty || write_en;
endmodule
